// File: rtl/pattern_gen.sv
// pattern_gen: drives stimulus patterns to a pattern detector and waits for
// its match flag. Each pattern carries a fixed target field taken from code
// plus five free bits from a 5-bit LFSR, so successive patterns differ in
// the bits the detector should ignore.
module pattern_gen #(
    parameter int unsigned TIMEOUT   = 8,        // WAIT_ACK cycles before giving up, 1..255
    parameter logic [4:0]  LFSR_SEED = 5'b10101  // must be nonzero
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       start,
    input  logic [2:0] code,
    input  logic [3:0] count,
    output logic [3:0] a_out,
    output logic [3:0] b_out,
    output logic       valid,
    input  logic       status_in,
    output logic       status_clr,
    output logic       busy,
    output logic       done,
    output logic       timeout_err,
    output logic [3:0] match_cnt
);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        DRIVE    = 3'd1,
        WAIT_ACK = 3'd2,
        CLEAR    = 3'd3,
        FINISH   = 3'd4,
        ERROR    = 3'd5
    } state_t;

    // Value of the wait counter on the TIMEOUT-th WAIT_ACK cycle (counter
    // starts at 0 on entry), i.e. the last cycle a match is still accepted.
    localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

    state_t     state;
    state_t     next_state;
    logic [2:0] code_q;      // latched target pattern
    logic [3:0] remaining;   // patterns still to be acknowledged
    logic [7:0] wait_cnt;    // cycles spent in the current WAIT_ACK
    logic [4:0] lfsr;        // free-bit generator, x^5+x^3+1
    logic [4:0] pat_q;       // free bits of the pattern on the wire
    logic [3:0] match_q;
    logic       err_q;

    logic       accept;      // start taken in IDLE
    logic       ack;         // detector acknowledged the current pattern
    logic       expire;      // last wait cycle passed without acknowledgement
    logic [4:0] free_bits;

    assign accept = (state == IDLE) && start;
    assign ack    = (state == WAIT_ACK) && status_in;
    assign expire = (state == WAIT_ACK) && !status_in && (wait_cnt == WAIT_LAST);

    // State register.
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of block evaluation order.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state <= IDLE;
        else       state <= next_state;
    end

    // Next-state logic; a same-cycle match wins over the timeout.
    always_comb begin
        next_state = state;
        unique case (state)
            IDLE:     if (start) next_state = (count == 4'd0) ? FINISH : DRIVE;
            DRIVE:    next_state = WAIT_ACK;
            WAIT_ACK: begin
                if (status_in)                    next_state = CLEAR;
                else if (wait_cnt == WAIT_LAST)   next_state = ERROR;
            end
            CLEAR:    next_state = (remaining != 4'd0) ? DRIVE : FINISH;
            FINISH:   next_state = IDLE;
            ERROR:    next_state = IDLE;
            default:  next_state = IDLE;
        endcase
    end

    // Burst bookkeeping: latched request, remaining count, match count, error flag.
    // NOTE: every register here is a plain flop with a reset value; there is
    // no storage array, so resetting all of it costs nothing special.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            code_q    <= 3'd0;
            remaining <= 4'd0;
            match_q   <= 4'd0;
            err_q     <= 1'b0;
        end else begin
            if (accept) begin
                code_q    <= code;
                remaining <= count;
                match_q   <= 4'd0;
                err_q     <= 1'b0;
            end
            if (ack) begin
                remaining <= remaining - 4'd1;
                match_q   <= match_q + 4'd1;   // wraps 15 -> 0
            end
            if (expire) err_q <= 1'b1;
        end
    end

    // Wait counter: cleared in DRIVE, which is the only way into WAIT_ACK.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)                  wait_cnt <= 8'd0;
        else if (state == DRIVE)    wait_cnt <= 8'd0;
        else if (state == WAIT_ACK) wait_cnt <= wait_cnt + 8'd1;
    end

    // LFSR advances once per DRIVE; the value shown in DRIVE is kept for WAIT_ACK.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            lfsr  <= LFSR_SEED;
            pat_q <= 5'd0;
        end else if (state == DRIVE) begin
            lfsr  <= {lfsr[3:0], lfsr[4] ^ lfsr[2]};
            pat_q <= lfsr;
        end
    end

    assign free_bits = (state == DRIVE) ? lfsr : pat_q;

    // Output decode from the current state.
    // NOTE: all outputs get a default before the case so no path leaves one
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        valid      = 1'b0;
        a_out      = 4'd0;
        b_out      = 4'd0;
        status_clr = 1'b0;
        done       = 1'b0;
        busy       = (state != IDLE);
        unique case (state)
            DRIVE, WAIT_ACK: begin
                valid = 1'b1;
                a_out = {code_q[1:0], free_bits[1:0]};
                b_out = {free_bits[4:3], code_q[2], free_bits[2]};
            end
            CLEAR:   status_clr = 1'b1;
            ERROR:   status_clr = 1'b1;
            FINISH:  done       = 1'b1;
            default: ;
        endcase
    end

    assign timeout_err = err_q;
    assign match_cnt   = match_q;

endmodule

// File: tb/tb_pattern_gen.sv
// tb_pattern_gen: directed bursts against pattern_gen. A transaction-level
// model expands each burst into its expected per-cycle output trace; one
// compare process checks every cycle against that trace (or against the idle
// values when no burst is pending). A detector model answers each pattern
// after a per-pattern delay. A few hand-computed literals pin the model.
`timescale 1ns/1ps
module tb_pattern_gen;

    localparam int         TIMEOUT = 8;
    localparam logic [4:0] SEED    = 5'b10101;

    logic       clk = 1'b0;
    logic       rstn = 1'b0;
    logic       start = 1'b0;
    logic [2:0] code = 3'd0;
    logic [3:0] count = 4'd0;
    logic [3:0] a_out, b_out, match_cnt;
    logic       valid, status_clr, busy, done, timeout_err;
    logic       status_in = 1'b0;

    pattern_gen #(.TIMEOUT(TIMEOUT), .LFSR_SEED(SEED)) dut (
        .clk(clk), .rstn(rstn), .start(start), .code(code), .count(count),
        .a_out(a_out), .b_out(b_out), .valid(valid), .status_in(status_in),
        .status_clr(status_clr), .busy(busy), .done(done),
        .timeout_err(timeout_err), .match_cnt(match_cnt)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       valid;
        logic [3:0] a;
        logic [3:0] b;
        logic       clr;
        logic       busy;
        logic       done;
        logic       err;
        logic [3:0] mc;
    } obs_t;

    int   n_checks = 0;
    int   n_fail   = 0;
    obs_t exp_q[$];

    // Model state between bursts.
    logic [4:0] model_lfsr = SEED;
    logic       model_err  = 1'b0;
    logic [3:0] model_mc   = 4'd0;

    // Detector model: per-pattern response delay in cycles after valid rises (0 = never).
    int         det_delays[16];
    int         det_idx = 0;
    int         det_age = 0;
    int         det_cur = 0;
    logic       prev_valid = 1'b0;
    logic [4:0] drive_dc[$];   // free bits seen on each new pattern

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s @%0t: got %h, expected %h", name, $time, act, req);
        end
    endtask

    function automatic obs_t mk(input logic v, input logic [3:0] a, input logic [3:0] b,
                                input logic clr, input logic bsy, input logic dn,
                                input logic er, input logic [3:0] mc);
        obs_t o;
        o.valid = v; o.a = a; o.b = b; o.clr = clr;
        o.busy = bsy; o.done = dn; o.err = er; o.mc = mc;
        return o;
    endfunction

    function automatic obs_t idle_obs();
        return mk(1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, model_err, model_mc);
    endfunction

    // x^5 + x^3 + 1, shift toward MSB, feedback = old bit 5 xor old bit 3 (1-based).
    function automatic logic [4:0] lfsr_step(input logic [4:0] v);
        int x;
        x = int'(v);
        return 5'(((x * 2) % 32) + (((x / 16) + (x / 4)) % 2));
    endfunction

    // Expand one accepted burst into its cycle-by-cycle expected outputs.
    task automatic plan_burst(input logic [2:0] c, input int n);
        int         mc;
        logic       aborted;
        logic [4:0] pat;
        logic [3:0] a, b;
        int         d, waits;
        exp_q.push_back(idle_obs());   // the IDLE cycle in which start is seen
        mc = 0;
        aborted = 1'b0;
        for (int i = 0; i < n; i++) begin
            if (!aborted) begin
                pat = model_lfsr;
                model_lfsr = lfsr_step(model_lfsr);
                a = {c[1:0], pat[1:0]};
                b = {pat[4:3], c[2], pat[2]};
                exp_q.push_back(mk(1, a, b, 0, 1, 0, 0, 4'(mc)));
                d = det_delays[i];
                waits = (d != 0 && d <= TIMEOUT) ? d : TIMEOUT;
                for (int w = 0; w < waits; w++) exp_q.push_back(mk(1, a, b, 0, 1, 0, 0, 4'(mc)));
                if (d != 0 && d <= TIMEOUT) begin
                    mc = (mc + 1) % 16;
                    exp_q.push_back(mk(0, 0, 0, 1, 1, 0, 0, 4'(mc)));
                end else begin
                    exp_q.push_back(mk(0, 0, 0, 1, 1, 0, 1, 4'(mc)));
                    aborted = 1'b1;
                end
            end
        end
        if (!aborted) exp_q.push_back(mk(0, 0, 0, 0, 1, 1, 0, 4'(mc)));
        model_err = aborted;
        model_mc  = 4'(mc);
    endtask

    // Called at posedge+1 while the DUT is idle; returns at posedge+1 of the next cycle.
    task automatic run_burst(input logic [2:0] c, input logic [3:0] n, input logic hold);
        code  = c;
        count = n;
        start = 1'b1;
        plan_burst(c, int'(n));
        @(posedge clk); #1;
        if (hold) begin
            @(posedge clk); #1;   // start stays high into the burst and must be ignored
        end
        start = 1'b0;
        code  = ~c;               // latched values must not follow the inputs
        count = ~n;
    endtask

    task automatic wait_drain(input string name);
        int k;
        k = 0;
        while (exp_q.size() != 0 && k < 300) begin
            @(posedge clk); #1;
            k++;
        end
        check({name, "_drain"}, 32'(exp_q.size()), 32'd0);
        exp_q.delete();
        repeat (2) begin @(posedge clk); #1; end
    endtask

    // Per-cycle compare against the model trace.
    always @(negedge clk) begin
        obs_t e, got;
        e = (exp_q.size() > 0) ? exp_q.pop_front() : idle_obs();
        got = mk(valid, a_out, b_out, status_clr, busy, done, timeout_err, match_cnt);
        check("cycle_trace", 32'(got), 32'(e));
    end

    // Detector model: sticky flag set det_delays[i] cycles after pattern i appears.
    always @(posedge clk) begin
        #1;
        if (!rstn) begin
            status_in  = 1'b0;
            prev_valid = 1'b0;
            det_idx    = 0;
        end else begin
            if (!busy) det_idx = 0;
            if (status_clr) status_in = 1'b0;
            if (valid && !prev_valid) begin
                det_age = 0;
                det_cur = det_delays[det_idx % 16];
                det_idx++;
                drive_dc.push_back({b_out[3:2], b_out[0], a_out[1:0]});
            end else if (valid) begin
                det_age++;
                if (det_cur != 0 && det_age == det_cur) status_in = 1'b1;
            end
            prev_valid = valid;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        for (int i = 0; i < 16; i++) det_delays[i] = 0;
        repeat (2) @(posedge clk);
        #1 rstn = 1'b1;
        repeat (2) begin @(posedge clk); #1; end

        // Single pattern, code 001, detector answers 2 cycles after valid.
        det_delays[0] = 2;
        run_burst(3'b001, 4'd1, 1'b0);
        check("t1_drive_a", 32'(a_out), 32'h5);   // {01, seed[1:0]=01}
        check("t1_drive_b", 32'(b_out), 32'h9);   // {seed[4:3]=10, 0, seed[2]=1}
        check("t1_drive_valid", 32'(valid), 32'd1);
        wait_drain("t1");
        check("t1_match_cnt", 32'(match_cnt), 32'd1);
        check("t1_timeout_err", 32'(timeout_err), 32'd0);

        // Three patterns, responsive detector, start held into the burst.
        det_delays[0] = 1; det_delays[1] = 3; det_delays[2] = 2;
        base = drive_dc.size();
        run_burst(3'b110, 4'd3, 1'b1);
        wait_drain("t2");
        check("t2_patterns", 32'(drive_dc.size() - base), 32'd3);
        if (drive_dc.size() - base == 3) begin
            check("t2_dc0", 32'(drive_dc[base]),     32'h0A);
            check("t2_dc1", 32'(drive_dc[base + 1]), 32'h14);
            check("t2_dc2", 32'(drive_dc[base + 2]), 32'h08);
            check("t2_dc_differ01", 32'(drive_dc[base] != drive_dc[base + 1]), 32'd1);
            check("t2_dc_differ12", 32'(drive_dc[base + 1] != drive_dc[base + 2]), 32'd1);
        end
        check("t2_match_cnt", 32'(match_cnt), 32'd3);

        // Detector never answers: timeout after TIMEOUT wait cycles, no done.
        det_delays[0] = 0; det_delays[1] = 0;
        run_burst(3'b011, 4'd2, 1'b0);
        wait_drain("t3");
        repeat (3) begin @(posedge clk); #1; end
        check("t3_err_sticky", 32'(timeout_err), 32'd1);
        check("t3_match_cnt", 32'(match_cnt), 32'd0);

        // Empty burst: straight to FINISH, clears the sticky error.
        run_burst(3'b111, 4'd0, 1'b0);
        wait_drain("t4");
        check("t4_err_cleared", 32'(timeout_err), 32'd0);
        check("t4_match_cnt", 32'(match_cnt), 32'd0);

        // Answer on the last allowed wait cycle counts as a match.
        det_delays[0] = TIMEOUT;
        run_burst(3'b010, 4'd1, 1'b0);
        wait_drain("t5");
        check("t5_match_cnt", 32'(match_cnt), 32'd1);
        check("t5_no_err", 32'(timeout_err), 32'd0);

        // Reset in the middle of WAIT_ACK.
        det_delays[0] = 0; det_delays[1] = 0;
        run_burst(3'b101, 4'd2, 1'b0);
        repeat (2) begin @(posedge clk); #1; end
        rstn = 1'b0;
        exp_q.delete();
        model_lfsr = SEED;
        model_err  = 1'b0;
        model_mc   = 4'd0;
        #1;
        check("t6_outputs_in_reset",
              32'({valid, a_out, b_out, status_clr, busy, done, timeout_err, match_cnt}), 32'd0);
        repeat (2) begin @(posedge clk); #1; end
        rstn = 1'b1;
        repeat (2) begin @(posedge clk); #1; end

        // Normal burst after reset restarts the LFSR from its seed.
        det_delays[0] = 1;
        base = drive_dc.size();
        run_burst(3'b100, 4'd1, 1'b0);
        wait_drain("t7");
        check("t7_patterns", 32'(drive_dc.size() - base), 32'd1);
        if (drive_dc.size() > base) check("t7_seed", 32'(drive_dc[base]), 32'h15);
        check("t7_match_cnt", 32'(match_cnt), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
